keypad_scan_rx: RTL and testbench
=================================

Name: keypad_scan_rx

Overview:
- Matrix-keypad input peripheral for the picosoc iomem bus; the input-side counterpart of the multiplexed 7-segment display driver.
- Strobes four active-low rows one-hot, samples four active-low columns, and debounces presses.
- Decodes each confirmed press to a 4-bit hex key code and queues it in a small FIFO.
- Firmware reads the FIFO through an iomem responder window.

Parameters:
- BASE_HI, 8'h05, iomem_addr[31:24] value decoded by this block.
- SCAN_DIV, 4000, clk cycles each row is driven (about 250 us at 16 MHz); must be >= 4.
- DEBOUNCE_FRAMES, 8, consecutive identical full scan frames needed to accept a press or a release; must be >= 1.
- FIFO_DEPTH, 8, key-code FIFO entries; power of 2, >= 2.

Ports:
- clk, in, 1, system clock.
- resetn, in, 1, synchronous, active-low reset.
- row_n, out, 4, one-hot active-low row strobe.
- col_n, in, 4, asynchronous active-low column sense (pulled up externally).
- iomem_valid, in, 1, bus request.
- iomem_ready, out, 1, one-cycle response strobe.
- iomem_wstrb, in, 4, byte write strobes; 0 means read.
- iomem_addr, in, 32, byte address.
- iomem_wdata, in, 32, write data.
- iomem_rdata, out, 32, read data; valid while iomem_ready=1.

Behaviour:
- Reset: while resetn=0 at a clk edge, the following are forced:
  - row_n=4'b1111, iomem_ready=0, iomem_rdata=0.
  - FIFO empty, overflow=0, enable=1.
  - FSM=IDLE, row index=0, all counters=0.
- Scan:
  - col_n passes through a 2-flop synchronizer.
  - Row r (0..3) is driven low for SCAN_DIV cycles, in the order 0,1,2,3 and then wrapping to 0.
  - Synchronized columns are sampled on the last cycle of each row slot.
  - One frame = 4 slots. At the end of a frame, the frame result is one of three values:
    - NONE: no column asserted in any row.
    - KEY(code = row*4 + col): exactly one row/col intersection asserted.
    - MULTI: more than one intersection asserted. MULTI is treated as NONE for acceptance and resets the debounce counter.
  - When enable=0, row_n=4'b1111, no samples are taken, and the FSM is held in IDLE.
- FSM, evaluated once per frame end:
  - IDLE: on KEY(k), set cand=k, cnt=1, go to CAND. Otherwise stay in IDLE.
  - CAND:
    - If KEY(cand) and cnt+1 == DEBOUNCE_FRAMES: push cand and go to HELD.
    - Else if KEY(cand): cnt++.
    - Otherwise (different key, NONE, MULTI): return to IDLE. A different key starts no new candidate until the next frame.
  - HELD: on KEY(cand), stay (no auto-repeat). Otherwise set cnt=1 and go to REL.
  - REL:
    - On KEY(cand): go to HELD.
    - Else if cnt+1 == DEBOUNCE_FRAMES: go to IDLE.
    - Else cnt++.
  - With DEBOUNCE_FRAMES=1, the push happens at the first KEY frame: IDLE goes directly to HELD, and REL goes directly to IDLE.
- FIFO:
  - A push when full drops the code and sets the sticky overflow bit.
  - A pop when empty has no effect.
  - A push and a pop in the same cycle both occur; count is unchanged. When full, a simultaneous push+pop succeeds.
  - Pointers wrap modulo FIFO_DEPTH.
- Bus:
  - When iomem_valid && !iomem_ready && iomem_addr[31:24]==BASE_HI, assert iomem_ready for exactly 1 cycle. Latency is 1 cycle, and iomem_rdata is registered.
  - Otherwise iomem_ready=0 and iomem_rdata holds its value.
  - Registers are decoded by iomem_addr[3:2]:
    - 0 DATA (read): {valid, 27'b0, code[3:0]}. valid=1 pops the head; when empty, returns 0. Writes are ignored.
    - 1 STATUS (read): {16'b0, overflow[15], 3'b0, down[11], cur_code[10:7], count[6:0]}. down=1 in HELD/REL. A write with wdata[15]=1 and wstrb[1]=1 clears overflow; a push in the same cycle that overflows wins.
    - 2 CTRL: bit0 enable, read/write with wstrb[0]. Writing 0 mid-scan resets the FSM and scan state but keeps the FIFO.
    - 3: reads 0; writes are ignored.

Optional Feature:
- KEYPAD_RX_IRQ_EN:
  - Defined: adds output irq (1 bit), registered and level-high while the FIFO is non-empty and CTRL bit1 (irq_en, reset 0) is set; CTRL bit1 becomes read/write.
  - Undefined: no irq port exists, and CTRL bit1 reads 0.

Decomposition:
- Shared package keypad_pkg holds:
  - register offsets: DATA=2'd0, STATUS=2'd1, CTRL=2'd2;
  - FSM state encoding: IDLE, CAND, HELD, REL;
  - frame-result encoding: NONE, KEY, MULTI.
- One sub-module: keypad_code_fifo (parameterised on depth; push/pop/full/empty/count).

Test Plan (SCAN_DIV=4, DEBOUNCE_FRAMES=3, FIFO_DEPTH=4):
- Hold row 2 / col 1 for 3 frames -> exactly one entry; DATA read returns 32'h8000_0009; a second read returns 0.
- Hold key 9 for 2 frames, release 1 frame, hold 3 frames -> one push only, code 9, STATUS down=1 during the hold.
- Press and release keys 0,5,A,F,3 (each 3 frames down, 3 frames up) without reads -> count=4, overflow=1; reads return 0,5,A,F; write STATUS 0x8000 -> overflow=0.
- Hold keys 1 and 6 together for 5 frames -> no push, FSM stays in IDLE; release 6 while 1 stays down -> key 1 pushed after 3 frames.
- Write CTRL=0 mid-candidate -> row_n=4'b1111 from the next cycle, no push; write CTRL=1 -> scanning restarts at row 0.
- Assert resetn=0 for 1 cycle while a FIFO entry exists and the FSM is in HELD -> FIFO empty, row_n=1111, iomem_ready=0, then row 0 strobe after reset.

Source files
------------

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - register offsets, debounce FSM states and frame-result encodings for keypad_scan_rx
package keypad_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  typedef enum logic [1:0] {IDLE, CAND, HELD, REL} key_state_t;

  typedef enum logic [1:0] {NONE, KEY, MULTI} frame_res_t;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  function automatic logic [1:0] lowest_set(input logic [3:0] v);
    if (v[0]) return 2'd0;
    if (v[1]) return 2'd1;
    if (v[2]) return 2'd2;
    return 2'd3;
  endfunction

endpackage

// File: rtl/keypad_code_fifo.sv
// rtl/keypad_code_fifo.sv - small key-code FIFO; a push into a full FIFO is accepted only alongside a pop
module keypad_code_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW + 1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/keypad_scan_rx.sv
// rtl/keypad_scan_rx.sv - 4x4 keypad scanner/debouncer with key-code FIFO on the iomem bus
// Optional irq output and CTRL.irq_en bit when KEYPAD_RX_IRQ_EN is defined.
module keypad_scan_rx
  import keypad_pkg::*;
#(
  parameter logic [7:0] BASE_HI         = 8'h05,
  parameter int         SCAN_DIV        = 4000,
  parameter int         DEBOUNCE_FRAMES = 8,
  parameter int         FIFO_DEPTH      = 8
) (
  input  logic        clk,
  input  logic        resetn,
  output logic [3:0]  row_n,
  input  logic [3:0]  col_n,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata
`ifdef KEYPAD_RX_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam int NW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_FRAMES - 1);

  logic [3:0]    col_m, col_s;
  logic          enable, enable_nxt;
  logic          scan_on;
  logic [1:0]    row_idx;
  logic [DW-1:0] div_cnt;
  logic [1:0]    acc_n;
  logic [3:0]    acc_code;
  key_state_t    state;
  logic [3:0]    cand;
  logic [CW-1:0] cnt;
  logic          overflow;

  logic [3:0]    hits;
  logic [2:0]    slot_n;
  logic [2:0]    tot;
  logic [1:0]    tot_sat;
  logic [3:0]    code_nxt;
  frame_res_t    fres;
  logic          slot_end, frame_end, key_now, key_cand, last_frame;
  logic          push;
  logic [3:0]    push_code;

  logic          bus_hit, bus_wr, ctrl_wr, pop, ovf_clr, down, irq_en_rd;
  logic [1:0]    reg_sel;
  logic [31:0]   rd_val;

  logic [3:0]    fifo_head;
  logic          fifo_full, fifo_empty;
  logic [NW-1:0] fifo_count;

  assign row_n = scan_on ? ~(4'b0001 << row_idx) : 4'b1111;

  assign reg_sel    = iomem_addr[3:2];
  assign bus_hit    = iomem_valid && !iomem_ready && (iomem_addr[31:24] == BASE_HI);
  assign bus_wr     = bus_hit && (iomem_wstrb != 4'h0);
  assign ctrl_wr    = bus_wr && (reg_sel == REG_CTRL) && iomem_wstrb[0];
  assign enable_nxt = ctrl_wr ? iomem_wdata[0] : enable;
  assign pop        = bus_hit && !bus_wr && (reg_sel == REG_DATA) && !fifo_empty;
  assign ovf_clr    = bus_wr && (reg_sel == REG_STATUS) && iomem_wstrb[1] && iomem_wdata[15];
  assign down       = (state == HELD) || (state == REL);

  assign slot_end  = scan_on && (div_cnt == DIV_LAST);
  assign frame_end = slot_end && (row_idx == 2'd3);

  // Per-frame accumulation: hit count saturates at 2 (>1 means MULTI), code keeps the first hit.
  always_comb begin
    hits     = ~col_s;
    slot_n   = popcount4(hits);
    tot      = {1'b0, acc_n} + slot_n;
    tot_sat  = (tot > 3'd1) ? 2'd2 : tot[1:0];
    code_nxt = acc_code;
    if (slot_n != 3'd0 && acc_n == 2'd0) code_nxt = {row_idx, lowest_set(hits)};
    fres = NONE;
    if (tot_sat == 2'd1)      fres = KEY;
    else if (tot_sat == 2'd2) fres = MULTI;
  end

  assign key_now    = frame_end && (fres == KEY);
  assign key_cand   = key_now && (code_nxt == cand);
  assign last_frame = (cnt == CNT_LAST);
  assign push       = enable_nxt &&
                      (((state == IDLE) && key_now && (DEBOUNCE_FRAMES == 1)) ||
                       ((state == CAND) && key_cand && last_frame));
  assign push_code  = (state == IDLE) ? code_nxt : cand;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      col_m <= 4'hF;
      col_s <= 4'hF;
    end else begin
      col_m <= col_n;
      col_s <= col_m;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn || !enable_nxt) begin
      scan_on  <= 1'b0;
      row_idx  <= 2'd0;
      div_cnt  <= '0;
      acc_n    <= 2'd0;
      acc_code <= 4'h0;
      state    <= IDLE;
      cnt      <= '0;
      if (!resetn) cand <= 4'h0;
    end else begin
      scan_on <= 1'b1;
      if (slot_end) begin
        div_cnt <= '0;
        row_idx <= row_idx + 2'd1;
        if (frame_end) begin
          acc_n    <= 2'd0;
          acc_code <= 4'h0;
        end else begin
          acc_n    <= tot_sat;
          acc_code <= code_nxt;
        end
      end else if (scan_on) begin
        div_cnt <= div_cnt + DW'(1);
      end

      if (frame_end) begin
        case (state)
          IDLE: if (key_now) begin
            cand  <= code_nxt;
            cnt   <= CW'(1);
            state <= (DEBOUNCE_FRAMES == 1) ? HELD : CAND;
          end
          CAND: begin
            if (!key_cand)       state <= IDLE;
            else if (last_frame) state <= HELD;
            else                 cnt   <= cnt + CW'(1);
          end
          HELD: if (!key_cand) begin
            cnt   <= CW'(1);
            state <= (DEBOUNCE_FRAMES == 1) ? IDLE : REL;
          end
          REL: begin
            if (key_cand)        state <= HELD;
            else if (last_frame) state <= IDLE;
            else                 cnt   <= cnt + CW'(1);
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_comb begin
    rd_val = 32'h0;
    case (reg_sel)
      REG_DATA:   if (!fifo_empty) rd_val = {1'b1, 27'h0, fifo_head};
      REG_STATUS: rd_val = {16'h0, overflow, 3'b000, down, cand, 7'(fifo_count)};
      REG_CTRL:   rd_val = {30'h0, irq_en_rd, enable};
      default:    rd_val = 32'h0;
    endcase
  end

  // An overflowing push in the same cycle as a clear leaves overflow set.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      iomem_ready <= 1'b0;
      iomem_rdata <= 32'h0;
      enable      <= 1'b1;
      overflow    <= 1'b0;
    end else begin
      iomem_ready <= bus_hit;
      if (bus_hit) iomem_rdata <= rd_val;
      enable <= enable_nxt;
      if (push && fifo_full && !pop) overflow <= 1'b1;
      else if (ovf_clr)              overflow <= 1'b0;
    end
  end

`ifdef KEYPAD_RX_IRQ_EN
  logic irq_en;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (ctrl_wr) irq_en <= iomem_wdata[1];
      irq <= irq_en && !fifo_empty;
    end
  end
  assign irq_en_rd = irq_en;
`else
  logic unused_irq_bit;
  assign irq_en_rd      = 1'b0;
  assign unused_irq_bit = iomem_wdata[1];
`endif

  logic unused_bus_bits;
  assign unused_bus_bits = ^{iomem_addr[23:4], iomem_addr[1:0], iomem_wdata[31:16],
                             iomem_wdata[14:2], iomem_wstrb[3:2]};

  keypad_code_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (4)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (push),
    .push_data (push_code),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_keypad_scan_rx.sv
// tb/tb_keypad_scan_rx.sv - directed bench for keypad_scan_rx: scan, debounce, FIFO and bus registers
module tb_keypad_scan_rx;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic        iomem_valid = 1'b0;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb = 4'h0;
  logic [31:0] iomem_addr = 32'h0;
  logic [31:0] iomem_wdata = 32'h0;
  logic [31:0] iomem_rdata;
`ifdef KEYPAD_RX_IRQ_EN
  logic        irq;
`endif

  logic [15:0] keys = 16'h0;
  logic [31:0] rd;
  int n_run  = 0;
  int n_fail = 0;

  localparam logic [31:0] M_ALL  = 32'hFFFF_FFFF;
  localparam logic [31:0] M_IDLE = 32'hFFFF_F87F;

  always #5 clk = ~clk;

  // Switch matrix model: a pressed key pulls its column low while its row is strobed.
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_n[r] && keys[r*4+c]) col_n[c] = 1'b0;
  end

  keypad_scan_rx #(
    .BASE_HI         (8'h05),
    .SCAN_DIV        (4),
    .DEBOUNCE_FRAMES (3),
    .FIFO_DEPTH      (4)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .row_n       (row_n),
    .col_n       (col_n),
    .iomem_valid (iomem_valid),
    .iomem_ready (iomem_ready),
    .iomem_wstrb (iomem_wstrb),
    .iomem_addr  (iomem_addr),
    .iomem_wdata (iomem_wdata),
    .iomem_rdata (iomem_rdata)
`ifdef KEYPAD_RX_IRQ_EN
    ,
    .irq         (irq)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_xfer(input logic [3:0] strb, input logic [3:0] off,
                          input logic [31:0] wd, output logic [31:0] data);
    int t = 0;
    @(negedge clk);
    iomem_valid = 1'b1;
    iomem_wstrb = strb;
    iomem_addr  = {8'h05, 20'h00000, off};
    iomem_wdata = wd;
    do begin
      @(negedge clk);
      t++;
    end while (!iomem_ready && t < 16);
    if (!iomem_ready) check("bus_ready_timeout", 32'(iomem_ready), 32'h1);
    data = iomem_rdata;
    iomem_valid = 1'b0;
    iomem_wstrb = 4'h0;
  endtask

  task automatic rd_check(input string tag, input logic [3:0] off,
                          input logic [31:0] exp, input logic [31:0] mask);
    logic [31:0] d;
    bus_xfer(4'h0, off, 32'h0, d);
    check(tag, d & mask, exp);
  endtask

  task automatic wr_reg(input logic [3:0] strb, input logic [3:0] off, input logic [31:0] wd);
    logic [31:0] d;
    bus_xfer(strb, off, wd, d);
  endtask

  // Returns at the negedge just after row 0 of the next frame is strobed.
  task automatic next_frame();
    int t = 0;
    while (row_n == 4'b1110 && t < 200) begin @(negedge clk); t++; end
    while (row_n != 4'b1110 && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) check("frame_timeout", 32'(row_n), 32'hE);
  endtask

  task automatic hold(input logic [15:0] mask, input int frames);
    keys = mask;
    repeat (frames) next_frame();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_row_n", 32'(row_n), 32'hF);
    check("rst_ready", 32'(iomem_ready), 32'h0);
    check("rst_rdata", iomem_rdata, 32'h0);
    resetn = 1'b1;
    @(negedge clk);
    check("first_strobe_row0", 32'(row_n), 32'hE);

    iomem_valid = 1'b1;
    iomem_addr  = 32'h0600_0004;
    repeat (3) @(negedge clk);
    check("addr_miss_no_ready", 32'(iomem_ready), 32'h0);
    iomem_valid = 1'b0;
    next_frame();

    // Single key 9 (row 2, col 1) held three frames.
    hold(16'h0200, 3);
    rd_check("t1_status_held", 4'h4, 32'h0000_0C81, M_ALL);
    rd_check("t1_data_first", 4'h0, 32'h8000_0009, M_ALL);
    @(negedge clk);
    check("t1_ready_one_cycle", 32'(iomem_ready), 32'h0);
    rd_check("t1_data_empty", 4'h0, 32'h0, M_ALL);
    rd_check("t1_reg3_zero", 4'hC, 32'h0, M_ALL);
    next_frame();
    hold(16'h0, 3);
    rd_check("t1_status_released", 4'h4, 32'h0, M_IDLE);
    next_frame();

    // Interrupted candidate then a full debounce: only one push.
    hold(16'h0200, 2);
    hold(16'h0, 1);
    hold(16'h0200, 3);
    rd_check("t2_status_one_push", 4'h4, 32'h0000_0C81, M_ALL);
    rd_check("t2_data", 4'h0, 32'h8000_0009, M_ALL);
    next_frame();
    hold(16'h0, 3);

    // Five presses into a four-entry FIFO.
    hold(16'h0001, 3); hold(16'h0, 3);
    hold(16'h0020, 3); hold(16'h0, 3);
    hold(16'h0400, 3); hold(16'h0, 3);
    hold(16'h8000, 3); hold(16'h0, 3);
    hold(16'h0008, 3); hold(16'h0, 3);
    rd_check("t3_status_ovf", 4'h4, 32'h0000_8004, M_IDLE);
    rd_check("t3_data_0", 4'h0, 32'h8000_0000, M_ALL);
    rd_check("t3_data_5", 4'h0, 32'h8000_0005, M_ALL);
    rd_check("t3_data_a", 4'h0, 32'h8000_000A, M_ALL);
    rd_check("t3_data_f", 4'h0, 32'h8000_000F, M_ALL);
    wr_reg(4'b0010, 4'h4, 32'h0000_8000);
    rd_check("t3_status_cleared", 4'h4, 32'h0, M_IDLE);
    next_frame();

    // Two keys at once are MULTI; dropping one lets the other debounce.
    hold(16'h0042, 5);
    rd_check("t4_status_multi", 4'h4, 32'h0, M_IDLE);
    next_frame();
    hold(16'h0002, 3);
    rd_check("t4_status_key1", 4'h4, 32'h0000_0881, M_ALL);
    rd_check("t4_data_key1", 4'h0, 32'h8000_0001, M_ALL);
    next_frame();
    hold(16'h0, 3);

    // Disable mid-candidate, then re-enable.
    hold(16'h0010, 1);
    wr_reg(4'b0001, 4'h8, 32'h0);
    check("t5_rows_off", 32'(row_n), 32'hF);
    rd_check("t5_ctrl_zero", 4'h8, 32'h0, M_ALL);
    rd_check("t5_status_idle", 4'h4, 32'h0, M_IDLE);
    keys = 16'h0;
    repeat (20) @(negedge clk);
    check("t5_rows_still_off", 32'(row_n), 32'hF);
    wr_reg(4'b0001, 4'h8, 32'h1);
    check("t5_restart_row0", 32'(row_n), 32'hE);
    rd_check("t5_ctrl_one", 4'h8, 32'h1, M_ALL);
    next_frame();
    next_frame();
    rd_check("t5_no_push", 4'h4, 32'h0, M_IDLE);
    next_frame();

    // Reset pulse while HELD with a queued entry.
    hold(16'h0200, 3);
    rd_check("t6_status_before", 4'h4, 32'h0000_0C81, M_ALL);
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    check("t6_rst_rows", 32'(row_n), 32'hF);
    check("t6_rst_ready", 32'(iomem_ready), 32'h0);
    resetn = 1'b1;
    keys = 16'h0;
    @(negedge clk);
    check("t6_row0_after_rst", 32'(row_n), 32'hE);
    rd_check("t6_status_after", 4'h4, 32'h0, M_ALL);
    rd_check("t6_data_after", 4'h0, 32'h0, M_ALL);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
